dm_arbiter: RTL
===============

// Module: dm_arbiter
// PURPOSE
//  Shares the single-port data memory (dm) between two requesters: port 0 is the pipeline
//  MEM stage (load/store) and port 1 is a debug/DMA loader. Two-state FSM, one dm access
//  per grant. Fixed CPU priority with a starvation limit that forces a DMA grant.
//  Drives dm wea/addra/dina/inst directly and returns douta to the winner.
// PARAMETERS
//  DM_WORDS     128  number of 32-bit words in dm; higher word indices are errors
//  STARVE_LIMIT 4    consecutive CPU grants while DMA is pending before DMA is forced
//  CNT_W        3    width of the starvation counter (must hold STARVE_LIMIT)
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  rst        in   1   reset, asynchronous, active-high
//  req0       in   1   CPU request; held high until ack0
//  we0        in   1   CPU write enable (1=store, 0=load)
//  addr0      in   32  CPU byte address; bits [1:0] ignored
//  wdata0     in   32  CPU store data
//  inst0      in   32  CPU instruction word, forwarded to dm for its write trace
//  ack0       out  1   one-cycle completion pulse for CPU
//  err0       out  1   valid with ack0: address out of range
//  rdata0     out  32  load data, valid only while ack0=1
//  req1/we1/addr1/wdata1  in  1/1/32/32  DMA request set, same rules as port 0
//  ack1/err1/rdata1       out 1/1/32     DMA response set, same rules as port 0
//  dm_wea     out  1   dm write strobe
//  dm_addra   out  10  dm word address = latched addr[11:2]
//  dm_dina    out  32  dm write data
//  dm_inst    out  32  dm trace instruction (latched inst0 for CPU, 0 for DMA)
//  dm_douta   in   32  dm combinational read data
// BEHAVIOUR
//  States: IDLE, ACCESS. Reset -> IDLE, all latches 0, starve_cnt 0, every output 0.
//  IDLE: if no req, stay. Else pick winner: DMA if req1 & (~req0 | starve_cnt==STARVE_LIMIT),
//   else CPU. Latch owner, we, addr, wdata, inst; go to ACCESS.
//  ACCESS (exactly 1 cycle): dm_addra/dm_dina/dm_inst from latches;
//   dm_wea = lat_we & ~lat_err (write commits at the posedge that leaves ACCESS);
//   ack<owner>=1; rdata<owner>=dm_douta; err<owner>=lat_err. Other port ack/err/rdata=0.
//   Next state is always IDLE.
//  Latency: req sampled in cycle T -> ack in T+1. Peak throughput: one access per 2 cycles.
//  Requester must deassert req the cycle after ack. A req seen in IDLE on the cycle after
//   ack is treated as a new request.
//  lat_err = (addr[31:2] >= DM_WORDS). On error: no write, rdata=0, ack still given.
//  starve_cnt: +1 on a CPU grant while req1=1, saturating at STARVE_LIMIT.
//   Cleared on any DMA grant and whenever req1=0 in IDLE.
//  Simultaneous req0 & req1 in IDLE: CPU wins unless the starvation limit is reached.
//  Reset in ACCESS: dm_wea drops immediately (async). The pending write is lost, no ack is given.
//  Outputs in IDLE: dm_wea=0, ack*=0, err*=0, rdata*=0; dm_addra/dm_dina hold the latched values.
// STRUCTURE
//  Shared header dm_arb_defs.vh: state encodings (S_IDLE=1'b0, S_ACCESS=1'b1),
//   owner IDs (OWN_CPU=1'b0, OWN_DMA=1'b1), DM_WORDS default.
//  One sub-module: dm_arb_starve_cnt (saturating counter: inc/clr/sat outputs, CNT_W wide).
//  Top holds the FSM, request latches and the response mux.
// TESTING
//  1 Reset mid-ACCESS, CPU store 0x10/0xAAAA5555 -> dm_wea falls async; no ack0; read 0x10 later -> old value.
//  2 CPU store addr 0x8 data 0xDEADBEEF, then load 0x8 -> ack0 at T+1 each; rdata0=0xDEADBEEF; dm_addra=2.
//  3 req0 & req1 both held continuously with STARVE_LIMIT=4 -> grant order CPU,CPU,CPU,CPU,DMA, repeating.
//  4 DMA store to addr 0x200 (word 128) -> ack1=1, err1=1, dm_wea stays 0, rdata1=0.
//  5 DMA alone, req1 held -> ack1 on every 2nd cycle; starve_cnt stays 0; dm_inst=0 while in ACCESS.
//  6 req0 rises in the same cycle ack1 is high -> CPU granted in the next IDLE; ack0 arrives 2 cycles later.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, owner IDs,
// default sizing and the address range check.
package dm_arbiter_pkg;
    typedef enum logic {S_IDLE = 1'b0, S_ACCESS = 1'b1} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

    localparam int DM_WORDS_DEF = 128;

    // One requester's sampled request set
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] inst;
    } dm_req_t;

    function automatic logic addr_oob(input logic [31:0] addr, input int words);
        return {2'b00, addr[31:2]} >= 32'(words);
    endfunction
endpackage

// File: rtl/dm_arbiter_if.sv
// Bundle of both requester ports and the dm side. The arbiter sits on the slave
// modport; requesters and the memory itself sit on the master side.
interface dm_arbiter_if;
    logic        req0, we0, ack0, err0;
    logic [31:0] addr0, wdata0, inst0, rdata0;
    logic        req1, we1, ack1, err1;
    logic [31:0] addr1, wdata1, rdata1;
    logic        dm_wea;
    logic [9:0]  dm_addra;
    logic [31:0] dm_dina, dm_inst, dm_douta;

    modport slave (
        input  req0, we0, addr0, wdata0, inst0,
        output ack0, err0, rdata0,
        input  req1, we1, addr1, wdata1,
        output ack1, err1, rdata1,
        output dm_wea, dm_addra, dm_dina, dm_inst,
        input  dm_douta
    );

    modport master (
        output req0, we0, addr0, wdata0, inst0,
        input  ack0, err0, rdata0,
        output req1, we1, addr1, wdata1,
        input  ack1, err1, rdata1,
        input  dm_wea, dm_addra, dm_dina, dm_inst,
        output dm_douta
    );
endinterface

// File: rtl/dm_arb_starve_cnt.sv
// Saturating counter of CPU grants handed out while DMA waits; sat tells the
// arbiter the DMA port must win the next grant.
module dm_arb_starve_cnt #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (inc && cnt != LIM) cnt <= cnt + 1'b1;
    end

    assign sat = (cnt == LIM);
endmodule

// File: rtl/dm_arbiter.sv
// Two-requester arbiter for the single-port dm: CPU has fixed priority, DMA is
// forced through after STARVE_LIMIT back-to-back CPU grants. One access per grant.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int DM_WORDS     = DM_WORDS_DEF,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  bus
);
    state_t      state, nxt;
    owner_t      lat_own;
    logic        lat_we, lat_err;
    logic [9:0]  lat_addr;
    logic [31:0] lat_wdata, lat_inst;

    logic    grant, dma_win, sat, cnt_inc, cnt_clr;
    dm_req_t sel;

    assign grant   = (state == S_IDLE) && (bus.req0 || bus.req1);
    assign dma_win = bus.req1 && (!bus.req0 || sat);

    // DMA never contributes a trace instruction
    always_comb begin
        sel = '0;
        if (dma_win) sel = '{we: bus.we1, addr: bus.addr1, wdata: bus.wdata1, inst: '0};
        else         sel = '{we: bus.we0, addr: bus.addr0, wdata: bus.wdata0, inst: bus.inst0};
    end

    assign cnt_inc = grant && !dma_win && bus.req1;
    assign cnt_clr = (grant && dma_win) || (state == S_IDLE && !bus.req1);

    dm_arb_starve_cnt #(.LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (grant) nxt = S_ACCESS;
            S_ACCESS: nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_own   <= OWN_CPU;
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_inst  <= '0;
        end else if (grant) begin
            lat_own   <= dma_win ? OWN_DMA : OWN_CPU;
            lat_we    <= sel.we;
            lat_err   <= addr_oob(sel.addr, DM_WORDS);
            lat_addr  <= sel.addr[11:2];
            lat_wdata <= sel.wdata;
            lat_inst  <= sel.inst;
        end
    end

    // Address/data/trace hold their latched values outside ACCESS; strobes only fire in ACCESS
    always_comb begin
        bus.dm_addra = lat_addr;
        bus.dm_dina  = lat_wdata;
        bus.dm_inst  = lat_inst;
        bus.dm_wea   = 1'b0;
        bus.ack0     = 1'b0;
        bus.err0     = 1'b0;
        bus.rdata0   = '0;
        bus.ack1     = 1'b0;
        bus.err1     = 1'b0;
        bus.rdata1   = '0;
        if (state == S_ACCESS) begin
            bus.dm_wea = lat_we && !lat_err;
            if (lat_own == OWN_DMA) begin
                bus.ack1   = 1'b1;
                bus.err1   = lat_err;
                bus.rdata1 = lat_err ? '0 : bus.dm_douta;
            end else begin
                bus.ack0   = 1'b1;
                bus.err0   = lat_err;
                bus.rdata0 = lat_err ? '0 : bus.dm_douta;
            end
        end
    end
endmodule
